// File: rtl/rcpu_io_bridge.sv
// RCPU SYS I/O bridge: TX/RX byte FIFOs, status, LEDs; read data registered one cycle after the strobe.
// TX drains on uart_tx_valid&&uart_tx_ready; full FIFOs drop pushes. Optional timer: define IO_TIMER_EN.
module rcpu_io_bridge #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4,
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_read_enable,
  input  logic             io_write_enable,
  input  logic [15:0]      io_address,
  input  logic [15:0]      io_write_data,
  output logic [15:0]      io_read_data,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic [LED_W-1:0] leds
);

  localparam int TX_D = 1 << TX_AW;
  localparam int RX_D = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_ONE = 1;
  localparam logic [RX_AW:0] RX_ONE = 1;

  logic [7:0]       r_tx_mem [TX_D];
  logic [7:0]       r_rx_mem [RX_D];
  logic [TX_AW:0]   r_tx_wp, r_tx_rp;
  logic [RX_AW:0]   r_rx_wp, r_rx_rp;
  logic             r_rx_ovf;
  logic [LED_W-1:0] r_led;
  logic [15:0]      r_rdata;

  logic w_in_map, w_sel_txd, w_sel_rxd, w_sel_stat, w_sel_led, w_sel_timl, w_sel_timh;
  logic w_tx_empty, w_tx_full, w_tx_pop, w_tx_push;
  logic w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_ovf_set;
  logic [15:0] w_led_ext, w_timl, w_timh, w_rdata;
  logic w_unused_ok;

  // Anything with upper address bits set is unmapped, whatever the low bits say.
  assign w_in_map   = (io_address[15:3] == 13'd0);
  assign w_sel_txd  = w_in_map && (io_address[2:0] == 3'd0);
  assign w_sel_rxd  = w_in_map && (io_address[2:0] == 3'd1);
  assign w_sel_stat = w_in_map && (io_address[2:0] == 3'd2);
  assign w_sel_led  = w_in_map && (io_address[2:0] == 3'd3);
  assign w_sel_timl = w_in_map && (io_address[2:0] == 3'd4);
  assign w_sel_timh = w_in_map && (io_address[2:0] == 3'd5);

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]) && (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]);
  assign w_tx_pop   = !w_tx_empty && uart_tx_ready;
  assign w_tx_push  = io_write_enable && w_sel_txd && (!w_tx_full || w_tx_pop);

  assign uart_tx_valid = !w_tx_empty;
  assign uart_tx_data  = r_tx_mem[r_tx_rp[TX_AW-1:0]];

  assign w_rx_empty   = (r_rx_wp == r_rx_rp);
  assign w_rx_full    = (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]) && (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]);
  assign w_rx_pop     = io_read_enable && w_sel_rxd && !w_rx_empty;
  assign w_rx_push    = uart_rx_valid && (!w_rx_full || w_rx_pop);
  assign w_rx_ovf_set = uart_rx_valid && w_rx_full && !w_rx_pop;

  assign w_unused_ok = ^io_write_data;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= io_write_data[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_ovf <= 1'b0;
      r_led    <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_ONE;
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_ONE;
      // A fresh overflow outranks the clear-on-read of STAT.
      if (w_rx_ovf_set)
        r_rx_ovf <= 1'b1;
      else if (io_read_enable && w_sel_stat)
        r_rx_ovf <= 1'b0;
      if (io_write_enable && w_sel_led) r_led <= io_write_data[LED_W-1:0];
      if (io_read_enable) r_rdata <= w_rdata;
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] r_timer;
  logic [15:0] r_shadow;

  // TIML read snapshots the upper half so a later TIMH read is coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer  <= '0;
      r_shadow <= '0;
    end else begin
      r_timer <= r_timer + 32'd1;
      if (io_read_enable && w_sel_timl) r_shadow <= r_timer[31:16];
    end
  end

  assign w_timl = r_timer[15:0];
  assign w_timh = r_shadow;
`else
  assign w_timl = '0;
  assign w_timh = '0;
`endif

  always_comb begin
    w_led_ext = '0;
    w_led_ext[LED_W-1:0] = r_led;
  end

  // Read mux sees pre-edge state, so a same-cycle write or push is not visible.
  always_comb begin
    w_rdata = '0;
    if (w_sel_rxd && !w_rx_empty) w_rdata = {8'h80, r_rx_mem[r_rx_rp[RX_AW-1:0]]};
    if (w_sel_stat) w_rdata = {12'd0, r_rx_ovf, !w_rx_empty, w_tx_empty, w_tx_full};
    if (w_sel_led)  w_rdata = w_led_ext;
    if (w_sel_timl) w_rdata = w_timl;
    if (w_sel_timh) w_rdata = w_timh;
  end

  assign io_read_data = r_rdata;
  assign leds         = r_led;

endmodule

// File: tb/tb_rcpu_io_bridge.sv
// Bench for rcpu_io_bridge: vector table, directed FIFO/reset/timer sequences, randomized queue-model run.
module tb_rcpu_io_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [15:0] io_address = '0;
  logic [15:0] io_write_data = '0;
  logic [15:0] io_read_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  leds;

  rcpu_io_bridge #(.TX_AW(4), .RX_AW(4), .LED_W(8)) dut (
    .clk(clk), .reset(reset),
    .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_address(io_address), .io_write_data(io_write_data), .io_read_data(io_read_data),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .leds(leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0]  seen_q[$];
  logic [31:0] mcyc = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic [7:0]  exp_led;
  } vec_t;
  vec_t vt[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    logic       acc;
    logic [7:0] b;
    acc = uart_tx_valid && uart_tx_ready;
    b   = uart_tx_data;
    @(posedge clk);
    #1;
    if (acc) seen_q.push_back(b);
    if (reset) mcyc = 0;
    else mcyc = mcyc + 1;
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                     input logic rxv, input logic [7:0] rxb);
    io_read_enable  = rd;
    io_write_enable = wr;
    io_address      = a;
    io_write_data   = wd;
    uart_rx_valid   = rxv;
    uart_rx_data    = rxb;
    tick();
    io_read_enable  = 1'b0;
    io_write_enable = 1'b0;
    uart_rx_valid   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(1'b1, 1'b0, a, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    logic        m_ovf, ovf_new, r_rd, r_wr, r_rxv;
    logic [7:0]  m_led, r_rxb;
    logic [15:0] m_rd, m_shadow, a, wd, ev;
    int          txn, rxn, r;

    vt[0]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0002, 8'h00};
    vt[1]  = '{1'b0, 1'b1, 16'h0003, 16'h00A5, 16'h0002, 8'hA5};
    vt[2]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h00A5, 8'hA5};
    vt[3]  = '{1'b1, 1'b1, 16'h0003, 16'h0003, 16'h00A5, 8'h03};
    vt[4]  = '{1'b1, 1'b1, 16'h0003, 16'h0007, 16'h0003, 8'h07};
    vt[5]  = '{1'b0, 1'b1, 16'h0003, 16'hFF12, 16'h0003, 8'h12};
    vt[6]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0012, 8'h12};
    vt[7]  = '{1'b0, 1'b1, 16'h0013, 16'h0055, 16'h0012, 8'h12};
    vt[8]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h0000, 8'h12};
    vt[9]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0012, 8'h12};
    vt[10] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000, 8'h12};
    vt[11] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0012, 8'h12};
    vt[12] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h12};
    vt[13] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0012, 8'h12};
    vt[14] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 16'h0000, 8'h12};
    vt[15] = '{1'b0, 1'b1, 16'h0002, 16'hFFFF, 16'h0000, 8'h12};
    vt[16] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0002, 8'h12};
    vt[17] = '{1'b0, 1'b1, 16'h0001, 16'h1234, 16'h0002, 8'h12};
    vt[18] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0002, 8'h12};
    vt[19] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 8'h12};

    do_reset();
    check("reset_rdata", io_read_data, 16'h0000);
    check("reset_leds", leds, 8'h00);
    check("reset_tx_valid", uart_tx_valid, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cyc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, 1'b0, 8'h0);
      check($sformatf("vec%0d_rdata", i), io_read_data, vt[i].exp_rd);
      check($sformatf("vec%0d_leds", i), leds, vt[i].exp_led);
    end

    // TX overfill with the serialiser stalled, then drain.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 16'h0000, 16'(i), 1'b0, 8'h0);
    rd(16'h0002);
    check("tx_full_stat", io_read_data, 16'h0001);
    seen_q.delete();
    uart_tx_ready = 1'b1;
    repeat (20) tick();
    check("tx_drain_count", seen_q.size(), 16);
    for (int i = 0; i < 16 && i < seen_q.size(); i++)
      check($sformatf("tx_byte%0d", i), seen_q[i], 8'(i));
    rd(16'h0002);
    check("tx_empty_stat", io_read_data, 16'h0002);

    // Park one byte in TX so tx_empty stays low through the RX tests.
    uart_tx_ready = 1'b0;
    cyc(1'b0, 1'b1, 16'h0000, 16'h00EE, 1'b0, 8'h0);

    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 8'h41 + 8'(i));
    rd(16'h0002);
    check("rx_ovf_stat", io_read_data, 16'h000C);
    rd(16'h0002);
    check("rx_ovf_cleared", io_read_data, 16'h0004);
    for (int i = 0; i < 16; i++) begin
      rd(16'h0001);
      check($sformatf("rx_read%0d", i), io_read_data, 16'h8041 + 16'(i));
    end
    rd(16'h0001);
    check("rx_read_empty", io_read_data, 16'h0000);
    rd(16'h0002);
    check("rx_drained_stat", io_read_data, 16'h0000);

    // Full RX: push and pop in the same cycle.
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 8'h60 + 8'(i));
    cyc(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 8'h70);
    check("rx_full_pushpop", io_read_data, 16'h8060);
    rd(16'h0002);
    check("rx_full_no_ovf", io_read_data, 16'h0004);
    for (int i = 1; i < 16; i++) begin
      rd(16'h0001);
      check($sformatf("rx_full_read%0d", i), io_read_data, 16'h8060 + 16'(i));
    end
    rd(16'h0001);
    check("rx_last_is_new", io_read_data, 16'h8070);
    rd(16'h0001);
    check("rx_after_last", io_read_data, 16'h0000);

    // Empty RX: push and pop in the same cycle.
    cyc(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 8'h99);
    check("rx_empty_pushpop", io_read_data, 16'h0000);
    rd(16'h0001);
    check("rx_empty_byte_kept", io_read_data, 16'h8099);

    // STAT read racing a new overflow.
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 8'h20 + 8'(i));
    cyc(1'b1, 1'b0, 16'h0002, 16'h0, 1'b1, 8'h31);
    check("stat_race_old", io_read_data, 16'h000C);
    rd(16'h0002);
    check("stat_race_kept", io_read_data, 16'h000C);
    rd(16'h0002);
    check("stat_race_clear", io_read_data, 16'h0004);
    for (int i = 0; i < 16; i++) begin
      rd(16'h0001);
      check($sformatf("rx_ovf_read%0d", i), io_read_data, 16'h8020 + 16'(i));
    end

    // Reset while TX is draining.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 16'h0000, 16'h00B0 + 16'(i), 1'b0, 8'h0);
    uart_tx_ready = 1'b1;
    tick();
    tick();
    check("pre_reset_tx_valid", uart_tx_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_reset_tx_valid", uart_tx_valid, 1'b0);
    check("mid_reset_rdata", io_read_data, 16'h0000);
    check("mid_reset_leds", leds, 8'h00);
    reset = 1'b0;
    rd(16'h0002);
    check("post_reset_stat", io_read_data, 16'h0002);

    // Randomized run against a queue-level model.
    m_txq.delete();
    m_rxq.delete();
    m_ovf = 1'b0;
    m_led = 8'h00;
    m_rd = 16'h0002;
    m_shadow = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      r_rd  = ($urandom_range(0, 1) == 1);
      r_wr  = ($urandom_range(0, 9) < 4);
      r_rxv = (i < 500) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 3);
      r_rxb = 8'($urandom);
      wd    = 16'($urandom);
      r     = $urandom_range(0, 15);
      if (r < 8) a = 16'(r);
      else a = {13'($urandom_range(1, 8191)), 3'(r)};
      if (i < 500 && $urandom_range(0, 3) == 0) a = 16'h0000;
      uart_tx_ready = (i < 500) ? ($urandom_range(0, 9) < 1) :
                      (i < 1000) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1);
      #1;
      txn = m_txq.size();
      rxn = m_rxq.size();
      check("rnd_tx_valid", uart_tx_valid, (txn > 0));
      if (txn > 0) check("rnd_tx_data", uart_tx_data, m_txq[0]);

      ev = 16'h0000;
      if (a[15:3] == 13'd0) begin
        case (a[2:0])
          3'd1: if (rxn > 0) ev = {8'h80, m_rxq[0]};
          3'd2: ev = {12'd0, m_ovf, (rxn > 0), (txn == 0), (txn == 16)};
          3'd3: ev = {8'h00, m_led};
`ifdef IO_TIMER_EN
          3'd4: ev = mcyc[15:0];
          3'd5: ev = m_shadow;
`endif
          default: ev = 16'h0000;
        endcase
      end
      if (r_rd) m_rd = ev;

      if (txn > 0 && uart_tx_ready) void'(m_txq.pop_front());
      if (r_wr && a == 16'h0000 && m_txq.size() < 16) m_txq.push_back(wd[7:0]);
      if (r_rd && a == 16'h0001 && rxn > 0) void'(m_rxq.pop_front());
      ovf_new = 1'b0;
      if (r_rxv) begin
        if (m_rxq.size() < 16) m_rxq.push_back(r_rxb);
        else ovf_new = 1'b1;
      end
      if (r_rd && a == 16'h0002) m_ovf = 1'b0;
      if (ovf_new) m_ovf = 1'b1;
      if (r_wr && a == 16'h0003) m_led = wd[7:0];
      if (r_rd && a == 16'h0004) m_shadow = mcyc[31:16];

      cyc(r_rd, r_wr, a, wd, r_rxv, r_rxb);
      check("rnd_rdata", io_read_data, m_rd);
      check("rnd_leds", leds, m_led);
    end
    seen_q.delete();

    // Timer registers.
    uart_tx_ready = 1'b0;
    do_reset();
`ifdef IO_TIMER_EN
    io_read_enable = 1'b1;
    io_address = 16'h0004;
    force dut.r_timer = 32'h0001FFFF;
    tick();
    release dut.r_timer;
    io_read_enable = 1'b0;
    check("timl", io_read_data, 16'hFFFF);
    tick();
    rd(16'h0005);
    check("timh_shadow", io_read_data, 16'h0001);
`else
    rd(16'h0003);
    rd(16'h0004);
    check("timl_absent", io_read_data, 16'h0000);
    rd(16'h0003);
    repeat (2) tick();
    rd(16'h0005);
    check("timh_absent", io_read_data, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
